// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake and instruction-memory write bus for instr_encoder_loader.
interface instr_encoder_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_class;
  logic [3:0]            in_alu_op;
  logic [2:0]            in_branch_cond;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [12:0]           in_imm;
  logic                  in_last;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output in_valid, in_class, in_alu_op, in_branch_cond, in_rd, in_rs1, in_rs2, in_imm, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_class, in_alu_op, in_branch_cond, in_rd, in_rs1, in_rs2, in_imm, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes decoded R/I/B instruction fields into RV32I words and writes them sequentially
// into instruction memory. Optional macro NOP_PAD_EN pads the program with NOPs to a 4-word boundary.
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  instr_encoder_loader_if.slave bus,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  done,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};
  localparam logic [31:0]           NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
`ifdef NOP_PAD_EN
    PAD  = 2'd3,
`endif
    DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  error_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;
  logic                  done_q;
  logic                  overflow_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;

  logic [31:0] enc_d;
  logic        illegal_d;
  logic [2:0]  funct3;

  assign funct3 = bus.in_alu_op[2:0];

  always_comb begin
    enc_d     = '0;
    illegal_d = 1'b0;
    case (bus.in_class)
      2'b00: enc_d = {1'b0, bus.in_alu_op[3], 5'b00000, bus.in_rs2, bus.in_rs1,
                      funct3, bus.in_rd, 7'b0110011};
      2'b01: begin
        illegal_d = bus.in_alu_op[3] && (funct3 != 3'b101);
        case (funct3)
          3'b001:  enc_d = {7'b0000000, bus.in_imm[4:0], bus.in_rs1, funct3, bus.in_rd, 7'b0010011};
          3'b101:  enc_d = {1'b0, bus.in_alu_op[3], 5'b00000, bus.in_imm[4:0], bus.in_rs1,
                            funct3, bus.in_rd, 7'b0010011};
          default: enc_d = {bus.in_imm[11:0], bus.in_rs1, funct3, bus.in_rd, 7'b0010011};
        endcase
      end
      2'b10: begin
        illegal_d = (bus.in_branch_cond[2:1] == 2'b01) || bus.in_imm[0];
        enc_d = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_branch_cond,
                 bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // Address and count advance at acceptance so back-to-back bundles land on consecutive words;
  // the address holds at the top word instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= BASE;
      count_q     <= '0;
      error_q     <= 1'b0;
      err_addr_q  <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      if (start) begin
        state_q    <= RUN;
        addr_q     <= BASE;
        count_q    <= '0;
        error_q    <= 1'b0;
        err_addr_q <= '0;
        done_q     <= 1'b0;
        overflow_q <= 1'b0;
      end else begin
        case (state_q)
          RUN: begin
            if (bus.in_valid) begin
              if (illegal_d) begin
                error_q <= 1'b1;
                if (!error_q) err_addr_q <= addr_q;
                if (bus.in_last) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
                end
              end else begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= addr_q;
                mem_wdata_q <= enc_d;
                count_q     <= count_q + 1'b1;
                if (addr_q == ADDR_MAX) begin
                  done_q     <= 1'b1;
                  overflow_q <= !bus.in_last;
                  state_q    <= DONE;
                end else begin
                  addr_q <= addr_q + 1'b1;
                  if (bus.in_last) begin
`ifdef NOP_PAD_EN
                    if (addr_q[1:0] == 2'b11) begin
                      done_q  <= 1'b1;
                      state_q <= DONE;
                    end else begin
                      state_q <= PAD;
                    end
`else
                    done_q  <= 1'b1;
                    state_q <= DONE;
`endif
                  end
                end
              end
            end
          end
`ifdef NOP_PAD_EN
          PAD: begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= NOP_WORD;
            count_q     <= count_q + 1'b1;
            if (addr_q == ADDR_MAX || addr_q[1:0] == 2'b11) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready  = (state_q == RUN);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign count         = count_q;
  assign error         = error_q;
  assign err_addr      = err_addr_q;
  assign done          = done_q;
  assign overflow      = overflow_q;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the instruction decoder: takes decoded instruction fields (class, alu_op, branch_cond, registers, immediate) and encodes them into RV32I words.
- Covers the R-type ALU, I-type ALU and B-type branch formats.
- Writes the encoded words sequentially into instruction memory from a programmable base.
- Used by the bench and the boot loader to build test programs for the core.

Parameters:
- ADDR_WIDTH, 8, word-address width of the instruction memory.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse: rewind to BASE_ADDR, clear error/done/overflow, enter RUN.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  block accepts a bundle this cycle.
- in_class  input  2  00 R-ALU, 01 I-ALU, 10 branch, 11 reserved.
- in_alu_op  input  4  {funct7[5], funct3}, same coding the decoder produces.
- in_branch_cond  input  3  branch funct3.
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_imm  input  13  signed immediate; I uses [11:0], B uses [12:0].
- in_last  input  1  final bundle of the program.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_WIDTH  write word address.
- mem_wdata  output  32  encoded instruction.
- count  output  ADDR_WIDTH+1  words written since start.
- error  output  1  sticky: an illegal bundle was seen.
- err_addr  output  ADDR_WIDTH  address at which the first illegal bundle arrived.
- done  output  1  sticky: last word written, or memory full.
- overflow  output  1  sticky: memory filled before in_last.

Behaviour:
Reset values:
- All outputs 0; state IDLE; address register = BASE_ADDR.

States:
- IDLE: in_ready=0; start -> RUN.
- RUN: in_ready=1 unless a write is pending and memory is full; last/full -> DONE.
- DONE: in_ready=0; start -> RUN.
- start has priority over everything in any state, including a same-cycle handshake; that handshake is dropped.

Handshake and timing:
- A transfer occurs when in_valid && in_ready.
- Fields are encoded and registered; mem_we pulses exactly 1 cycle after acceptance, with mem_addr/mem_wdata valid in that cycle.
- Back-to-back acceptance is allowed, giving 1 word per cycle.
- Address increments after each write; count increments on each write.

Encoding, R (class 00):
- {0, alu_op[3], 00000, rs2, rs1, alu_op[2:0], rd, 0110011}.

Encoding, I (class 01):
- Default: {imm[11:0], rs1, alu_op[2:0], rd, 0010011}.
- funct3=001: bits[31:25]=0, shamt=imm[4:0].
- funct3=101: bits[31:25]={0, alu_op[3], 00000}, shamt=imm[4:0].

Encoding, B (class 10):
- {imm[12], imm[10:5], rs2, rs1, cond, imm[4:1], imm[11], 1100011}.

Illegal bundles:
- Any of: class 11; I with alu_op[3]=1 and funct3≠101; B with cond 010/011; B with imm[0]=1.
- Effect: bundle consumed, no write, address/count unchanged.
- error set; err_addr captures the current address on the first error only.
- An illegal in_last bundle still sets done.

Completion and full:
- The write of an in_last bundle sets done and moves to DONE.
- The write to address 2^ADDR_WIDTH-1 sets done and moves to DONE. If that word was not in_last, overflow is also set.
- The address never wraps.

Reset mid-operation:
- A pending write is discarded; no mem_we is issued.

Optional Feature:
- Macro: NOP_PAD_EN.
- With it defined: after the in_last write, the block emits NOP words 0x00000013 on consecutive cycles, with in_ready=0, until the address is a multiple of 4. done is set after the final pad. Pad writes count. Full still terminates padding.
- Without it: no padding; done is set on the in_last write.

Test Plan:
- start; R add rd3 rs1 1 rs2 2 (alu_op 0000) -> mem_we next cycle, addr 0, data 0x002081B3; count=1.
- Back-to-back: R sub rd5 rs1 6 rs2 7 (alu_op 1000), then I addi rd1 rs1 0 imm -1 -> 0x407302B3 @0 and 0xFFF00093 @1 on consecutive cycles.
- I srai rd2 rs1 2 imm 3 (alu_op 1101) followed by B beq rs1 1 rs2 2 imm -8 with in_last -> 0x40315113 and 0xFE208CE3; done=1, in_ready=0.
- B with cond 010 at addr 2 -> no mem_we, error=1, err_addr=2; the next legal bundle is written at addr 2.
- ADDR_WIDTH=2, 5 bundles without in_last -> writes at 0..3; done=1 and overflow=1 after addr 3; 5th bundle never accepted.
- rst asserted in the cycle after acceptance -> no mem_we, all outputs 0. With NOP_PAD_EN: 1 bundle with in_last -> NOPs written at 1,2,3, then done.
